// File: rtl/collision_scheduler_if.sv
// Object coordinate read port: the scheduler strobes an index and the object
// mux returns that object's box one cycle later.
interface collision_scheduler_if #(
  parameter int N_OBJ = 8,
  parameter int W     = 10,
  localparam int IW   = (N_OBJ > 1) ? $clog2(N_OBJ) : 1
);
  logic          obj_rd;
  logic [IW-1:0] obj_idx;
  logic [W-1:0]  obj_x;
  logic [W-1:0]  obj_y;
  logic [W-1:0]  obj_w;
  logic [W-1:0]  obj_h;

  modport master (
    output obj_rd, obj_idx,
    input  obj_x, obj_y, obj_w, obj_h
  );

  modport slave (
    input  obj_rd, obj_idx,
    output obj_x, obj_y, obj_w, obj_h
  );
endinterface

// File: rtl/collision_scheduler.sv
// Per-frame scheduler sharing one bounding-box comparator across N_OBJ objects;
// scans requested objects in ascending order and publishes hit/hit_top vectors.
module collision_scheduler #(
  parameter int N_OBJ      = 8,
  parameter int W          = 10,
  parameter int TOP_MARGIN = 4,
  localparam int IW        = (N_OBJ > 1) ? $clog2(N_OBJ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_start,
  input  logic [N_OBJ-1:0]       req,
  input  logic [W-1:0]           mario_x,
  input  logic [W-1:0]           mario_y,
  input  logic [W-1:0]           mario_w,
  input  logic [W-1:0]           mario_h,
  collision_scheduler_if.master  obj_bus,
  output logic [N_OBJ-1:0]       hit,
  output logic [N_OBJ-1:0]       hit_top,
  output logic                   done,
  output logic                   busy,
  output logic                   overrun
);

  typedef enum logic [1:0] {IDLE, SCAN, CHECK} state_t;

  state_t         state;
  logic [IW-1:0]  i;
  logic [IW-1:0]  i_nxt;
  logic           last;
  logic [N_OBJ-1:0] req_q, hit_s, top_s, hit_n, top_n;
  logic [W-1:0]   m_x, m_y, m_w, m_h;
  logic [W:0]     m_far_x, m_far_y, o_far_x, o_far_y, o_top_lim;
  logic           ov, top;

  assign i_nxt           = i + 1'b1;
  assign last            = (i == IW'(N_OBJ - 1));
  assign obj_bus.obj_idx = i;

  // Far edges carry one extra bit so boxes near the screen edge never wrap.
  assign m_far_x   = {1'b0, m_x} + {1'b0, m_w};
  assign m_far_y   = {1'b0, m_y} + {1'b0, m_h};
  assign o_far_x   = {1'b0, obj_bus.obj_x} + {1'b0, obj_bus.obj_w};
  assign o_far_y   = {1'b0, obj_bus.obj_y} + {1'b0, obj_bus.obj_h};
  assign o_top_lim = {1'b0, obj_bus.obj_y} + (W+1)'(TOP_MARGIN);

  always_comb begin
    ov = (m_w != '0) && (m_h != '0) && (obj_bus.obj_w != '0) && (obj_bus.obj_h != '0)
      && ({1'b0, m_x} < o_far_x) && ({1'b0, obj_bus.obj_x} < m_far_x)
      && ({1'b0, m_y} < o_far_y) && ({1'b0, obj_bus.obj_y} < m_far_y);
    top = ov && (m_far_y <= o_top_lim);
    hit_n    = hit_s;
    top_n    = top_s;
    hit_n[i] = ov;
    top_n[i] = top;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      i              <= '0;
      req_q          <= '0;
      hit_s          <= '0;
      top_s          <= '0;
      m_x            <= '0;
      m_y            <= '0;
      m_w            <= '0;
      m_h            <= '0;
      hit            <= '0;
      hit_top        <= '0;
      done           <= 1'b0;
      busy           <= 1'b0;
      overrun        <= 1'b0;
      obj_bus.obj_rd <= 1'b0;
    end else begin
      done <= 1'b0;
      if (frame_start && (state != IDLE))
        overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (frame_start) begin
            req_q <= req;
            m_x   <= mario_x;
            m_y   <= mario_y;
            m_w   <= mario_w;
            m_h   <= mario_h;
            hit_s <= '0;
            top_s <= '0;
            i     <= '0;
            busy  <= 1'b1;
            // Strobe is registered one cycle ahead so it is high during the
            // SCAN cycle of each requested index.
            obj_bus.obj_rd <= req[0];
            state <= SCAN;
          end
        end
        SCAN: begin
          if (req_q[i]) begin
            obj_bus.obj_rd <= 1'b0;
            state          <= CHECK;
          end else if (last) begin
            hit     <= hit_s;
            hit_top <= top_s;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            i              <= i_nxt;
            obj_bus.obj_rd <= req_q[i_nxt];
          end
        end
        CHECK: begin
          hit_s <= hit_n;
          top_s <= top_n;
          if (last) begin
            hit     <= hit_n;
            hit_top <= top_n;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            i              <= i_nxt;
            obj_bus.obj_rd <= req_q[i_nxt];
            state          <= SCAN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_collision_scheduler.sv
// Directed bench for collision_scheduler: vector table of scans plus
// hand-written reset, overrun and back-to-back sequences.
module tb_collision_scheduler;
  localparam int N = 8;
  localparam int W = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_start = 1'b0;
  logic [N-1:0] req = '0;
  logic [W-1:0] mario_x = '0, mario_y = '0, mario_w = '0, mario_h = '0;
  logic [N-1:0] hit, hit_top;
  logic done, busy, overrun;

  collision_scheduler_if #(.N_OBJ(N), .W(W)) bus ();

  collision_scheduler #(.N_OBJ(N), .W(W), .TOP_MARGIN(4)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .req(req),
    .mario_x(mario_x), .mario_y(mario_y), .mario_w(mario_w), .mario_h(mario_h),
    .obj_bus(bus.master),
    .hit(hit), .hit_top(hit_top), .done(done), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]        req;
    logic [W-1:0]        mx, my, mw, mh;
    logic [N-1:0][W-1:0] ox, oy, ow, oh;
    logic [N-1:0]        hit, top;
    int                  lat;
  } vec_t;

  localparam int NV = 9;
  vec_t vec [NV];
  logic [N-1:0][W-1:0] cur_ox, cur_oy, cur_ow, cur_oh;
  int errors = 0;
  int checks = 0;

  // Registered object mux; a full-screen box when not strobed exposes any
  // sampling on the wrong cycle.
  always @(posedge clk) begin
    if (bus.obj_rd) begin
      bus.obj_x <= cur_ox[bus.obj_idx];
      bus.obj_y <= cur_oy[bus.obj_idx];
      bus.obj_w <= cur_ow[bus.obj_idx];
      bus.obj_h <= cur_oh[bus.obj_idx];
    end else begin
      bus.obj_x <= '0;
      bus.obj_y <= '0;
      bus.obj_w <= '1;
      bus.obj_h <= '1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic setv(input int v, input logic [N-1:0] r, input int mx, input int my,
                      input int mw, input int mh, input logic [N-1:0] h,
                      input logic [N-1:0] t, input int lat);
    vec[v].req = r;
    vec[v].mx = W'(mx); vec[v].my = W'(my); vec[v].mw = W'(mw); vec[v].mh = W'(mh);
    vec[v].ox = '0; vec[v].oy = '0; vec[v].ow = '0; vec[v].oh = '0;
    vec[v].hit = h; vec[v].top = t; vec[v].lat = lat;
  endtask

  task automatic so(input int v, input int k, input int x, input int y, input int w, input int h);
    vec[v].ox[k] = W'(x); vec[v].oy[k] = W'(y); vec[v].ow[k] = W'(w); vec[v].oh[k] = W'(h);
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  // Called 1 time unit after the edge that sampled frame_start.
  task automatic wait_done(output int lat, output logic [N-1:0] rdm, output int rdc);
    lat = 1; rdm = '0; rdc = 0;
    forever begin
      if (bus.obj_rd) begin
        rdm[bus.obj_idx] = 1'b1;
        rdc++;
      end
      if (done) break;
      if (lat >= 40) begin
        lat = 0;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic load(input int v);
    req = vec[v].req;
    mario_x = vec[v].mx; mario_y = vec[v].my; mario_w = vec[v].mw; mario_h = vec[v].mh;
    cur_ox = vec[v].ox; cur_oy = vec[v].oy; cur_ow = vec[v].ow; cur_oh = vec[v].oh;
  endtask

  task automatic run_vec(input int v);
    int lat, rdc;
    logic [N-1:0] rdm;
    load(v);
    pulse_start();
    // Scramble live inputs: only the snapshot may be used.
    req = ~vec[v].req;
    mario_x = '0; mario_y = '0; mario_w = '1; mario_h = '1;
    wait_done(lat, rdm, rdc);
    chk($sformatf("v%0d latency", v), lat, vec[v].lat);
    chk($sformatf("v%0d rd_mask", v), rdm, vec[v].req);
    chk($sformatf("v%0d rd_count", v), rdc, $countones(vec[v].req));
    chk($sformatf("v%0d hit", v), hit, vec[v].hit);
    chk($sformatf("v%0d hit_top", v), hit_top, vec[v].top);
    chk($sformatf("v%0d busy_at_done", v), busy, 0);
    @(posedge clk); #1;
    chk($sformatf("v%0d done_one_cycle", v), done, 0);
    chk($sformatf("v%0d hit_hold", v), hit, vec[v].hit);
  endtask

  initial begin
    int lat, rdc, dones;
    logic [N-1:0] rdm;

    setv(0, 8'h00, 100, 200, 16, 16, 8'h00, 8'h00, 9);
    setv(1, 8'h05, 100, 200, 16, 16, 8'h01, 8'h00, 11);
    so(1, 0, 110, 205, 16, 16); so(1, 2, 300, 200, 16, 16);
    so(1, 1, 100, 200, 16, 16);
    setv(2, 8'h80, 50, 100, 16, 32, 8'h80, 8'h80, 10);
    so(2, 7, 40, 130, 32, 16);
    setv(3, 8'h80, 50, 100, 16, 32, 8'h80, 8'h00, 10);
    so(3, 7, 40, 120, 32, 16);
    setv(4, 8'h02, 1016, 0, 16, 16, 8'h02, 8'h00, 10);
    so(4, 1, 1020, 0, 8, 8);
    setv(5, 8'h08, 0, 0, 16, 16, 8'h00, 8'h00, 10);
    so(5, 3, 16, 0, 8, 8);
    setv(6, 8'h10, 0, 0, 16, 16, 8'h00, 8'h00, 10);
    so(6, 4, 4, 4, 0, 8);
    setv(7, 8'hFF, 0, 0, 16, 16, 8'h23, 8'h22, 17);
    so(7, 0, 8, 8, 16, 16);    so(7, 1, 0, 14, 16, 8);
    so(7, 2, 0, 16, 16, 8);    so(7, 3, 20, 0, 4, 4);
    so(7, 4, 4, 4, 0, 8);      so(7, 5, 15, 15, 1, 1);
    so(7, 6, 0, 0, 16, 0);     so(7, 7, 1000, 1000, 16, 16);
    setv(8, 8'h03, 0, 0, 16, 16, 8'h03, 8'h01, 11);
    so(8, 0, 0, 12, 16, 8);    so(8, 1, 0, 11, 16, 8);

    cur_ox = '0; cur_oy = '0; cur_ow = '0; cur_oh = '0;
    #2 rst = 1'b0;
    #1;
    chk("reset hit", hit, 0);
    chk("reset hit_top", hit_top, 0);
    chk("reset done/busy/overrun", {done, busy, overrun}, 0);
    chk("reset obj_rd/idx", {bus.obj_rd, bus.obj_idx}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < NV; v++) run_vec(v);
    chk("overrun after table", overrun, 0);

    // frame_start coincident with done starts a new scan
    load(1);
    pulse_start();
    wait_done(lat, rdm, rdc);
    chk("b2b first latency", lat, 11);
    load(7);
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    chk("b2b busy", busy, 1);
    wait_done(lat, rdm, rdc);
    chk("b2b second latency", lat, 17);
    chk("b2b second hit", hit, 8'h23);
    chk("b2b overrun", overrun, 0);

    // frame_start while busy: ignored but sticky overrun
    @(posedge clk); #1;
    load(1);
    pulse_start();
    repeat (2) begin @(posedge clk); #1; end
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    chk("overrun set", overrun, 1);
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) dones++;
      @(posedge clk); #1;
    end
    chk("overrun single done", dones, 1);
    chk("overrun scan result", hit, 8'h01);
    chk("overrun sticky", overrun, 1);

    // reset mid-scan: immediate clear, no done afterwards
    load(7);
    pulse_start();
    repeat (3) begin @(posedge clk); #1; end
    #2 rst = 1'b0;
    #1;
    chk("midreset hit", hit, 0);
    chk("midreset hit_top", hit_top, 0);
    chk("midreset done/busy/overrun", {done, busy, overrun}, 0);
    chk("midreset obj_rd/idx", {bus.obj_rd, bus.obj_idx}, 0);
    @(negedge clk) rst = 1'b1;
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    chk("post-reset idle", dones, 0);
    run_vec(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/collision_scheduler.md
# collision_scheduler

Frame-rate scheduler that time-shares a single bounding-box collision comparator among up to N_OBJ game objects (bricks, question block, fungi, monster). On each frame-start pulse it snapshots the Mario box and the per-object request mask, then walks the objects in ascending index order. For each requested object it fetches coordinates through a registered read port and records overlap and top-landing results. It publishes the results as per-object vectors with a one-cycle `done` pulse, and sits between the VGA frame timing and the sprite/physics modules.

## Interface
- `N_OBJ`, 8: number of object slots; index width `IW = $clog2(N_OBJ)`.
- `W`, 10: coordinate/size width, matching the sprite coordinate buses.
- `TOP_MARGIN`, 4: pixel tolerance for classifying a hit as landing on top.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `frame_start`  in  1  one-cycle pulse marking the start of a frame.
- `req`  in  N_OBJ  per-object check request; e.g. fungi deasserts once eaten.
- `mario_x`, `mario_y`  in  W  Mario top-left corner.
- `mario_w`, `mario_h`  in  W  Mario size.
- `obj_rd`  out  1  read strobe for the object coordinate mux.
- `obj_idx`  out  IW  object index being read.
- `obj_x`, `obj_y`, `obj_w`, `obj_h`  in  W  object box; valid the cycle after `obj_rd`.
- `hit`  out  N_OBJ  overlap result per object from the last completed scan.
- `hit_top`  out  N_OBJ  landing-on-top result per object from the last completed scan.
- `done`  out  1  one-cycle pulse when `hit`/`hit_top` update.
- `busy`  out  1  high while a scan is in progress.
- `overrun`  out  1  sticky; set when `frame_start` arrives while busy.

## Operation
- Reset (`rst` = 0) applies immediately to every output and register: state IDLE, `hit`=0, `hit_top`=0, `done`=0, `busy`=0, `obj_rd`=0, `obj_idx`=0, `overrun`=0, index counter = 0, shadow vectors = 0.
- **IDLE**:
  - If `frame_start` is high, latch `req` into `req_q` and the Mario box into `m_*`.
  - Clear the shadow vectors, set the index counter `i`=0 and go to SCAN.
- **SCAN** (one cycle per index):
  - If `req_q[i]` is set: drive `obj_rd`=1 and `obj_idx`=i, then go to CHECK.
  - Otherwise: leave shadow bit i at 0. If i = N_OBJ-1, finish; else increment i and stay in SCAN.
- **CHECK**: sample `obj_*` and evaluate the comparator.
  - Write shadow bits `hit_s[i]` and `top_s[i]`.
  - If i = N_OBJ-1, finish; else increment i and return to SCAN.
- **Finish**:
  - On the same edge: `hit` <= `hit_s` and `hit_top` <= `top_s`, with bit N_OBJ-1 taking its value computed this cycle.
  - Set `done` to 1 for one cycle, clear `busy` and return to IDLE.
- **Comparator**: all sums are computed in W+1 bits so they never wrap.
  - ov = (mx < ox+ow) && (ox < mx+mw) && (my < oy+oh) && (oy < my+mh).
  - top = ov && (my+mh <= oy+TOP_MARGIN).
- Boundary cases:
  - A zero-width or zero-height box on either side gives ov = 0.
  - A box whose far edge exceeds 2^W-1 is compared correctly via the extra bit.
- Outputs `hit` and `hit_top` hold between scans and change only on the finishing edge.
- `req` changes and Mario input changes during a scan are ignored; the snapshot is used.
- Objects are scanned in strictly ascending index order; there is no round-robin rotation.

## Timing
- Frame start: `frame_start` is sampled at edge k while IDLE; `busy`=1 from k.
- First SCAN cycle is k+1.
- Scan length: L = N_OBJ + popcount(`req_q`) cycles (SCAN plus CHECK cycles).
- `done`=1 in cycle k+1+L; `busy`=0 in that same cycle.
- Object read: `obj_rd` is high exactly one cycle per requested object. `obj_*` must be valid in the following cycle (registered mux, latency 1).
- `frame_start` while busy:
  - The pulse is ignored and `overrun` is set; the current scan is unaffected.
  - `overrun` clears only on reset.
- `frame_start` in the same cycle `done` is high is accepted, because the block is IDLE then.
- Reset asserted mid-scan aborts the scan and returns all outputs to their reset values. After reset is released the block waits for the next `frame_start`.
- Worst case at N_OBJ=8 is 17 cycles, far below one frame.

## Test plan
- **Reset values:** hold `rst`=0 mid-scan -> all outputs 0 immediately; no `done` pulse after release until the next `frame_start`.
- **Empty mask:** `req`=8'h00, pulse `frame_start` -> `obj_rd` never high; `done` 9 cycles after the pulse; `hit`=0, `hit_top`=0.
- **Single overlap:**
  - Stimulus: `req`=8'h05; Mario (100,200,16,16); obj0 (110,205,16,16); obj2 (300,200,16,16).
  - Response: `obj_rd` for idx 0 and 2 only; `done` 11 cycles after the pulse; `hit`=8'h01, `hit_top`=8'h00.
- **Top landing:**
  - Stimulus: `req`=8'h80; Mario (50,100,16,32); obj7 (40,130,32,16).
  - Response: my+mh = 132 <= 134 -> `hit`=8'h80, `hit_top`=8'h80.
  - Moving obj7 to y=120 -> `hit`=8'h80, `hit_top`=8'h00.
- **Edge and width rules:**
  - Mario (1016,0,16,16) with obj (1020,0,8,8) -> hit (no wrap).
  - Boxes that only touch at x: Mario (0,0,16,16), obj (16,0,8,8) -> no hit.
  - obj width 0 -> no hit.
- **Overrun and snapshot:**
  - Second `frame_start` 3 cycles into a scan -> `overrun`=1 and sticky; exactly one `done`.
  - `req` toggled mid-scan -> results reflect the snapshot mask.
  - `frame_start` coincident with `done` -> a new scan starts.
